// File: rtl/punc_exec_datapath.sv
// rtl/punc_exec_datapath.sv - PUnC LC3 execution datapath with req/ack memory port
`timescale 1ns/1ps
module punc_exec_datapath #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] PC_RESET    = '0,
    parameter int                MEM_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    input  logic [2:0]        i_cmd_op,
    output logic              o_cmd_ready,
    output logic              o_done,
    output logic              o_err,
    output logic [15:0]       o_ir,
    output logic              o_n,
    output logic              o_z,
    output logic              o_p,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    input  logic [2:0]        i_rf_debug_addr,
    output logic [DATA_W-1:0] o_rf_debug_data,
    output logic [DATA_W-1:0] o_pc_debug_data
);
    localparam logic [2:0] OP_FETCH  = 3'd0;
    localparam logic [2:0] OP_ALU    = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam int         CNT_W     = $clog2(MEM_TIMEOUT + 2);

    typedef enum logic [2:0] {S_IDLE, S_MEM1, S_GAP, S_MEM2, S_POST, S_EXEC} state_t;

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_ir;
    logic [DATA_W-1:0]  r_pc;
    logic [DATA_W-1:0]  r_rf [8];
    logic               r_n, r_z, r_p;
    logic [2:0]         r_op;
    logic               r_err, r_two;
    logic [DATA_W-1:0]  r_mem_addr, r_mem_wdata, r_data;
    logic               r_mem_we;
    logic [CNT_W-1:0]   r_cnt;

    logic [3:0]         w_opc;
    logic [2:0]         w_dr, w_sr1, w_sr2;
    logic [DATA_W-1:0]  w_sext5, w_sext6, w_sext9, w_sext11;
    logic [DATA_W-1:0]  w_pc_off9, w_pc_off11, w_base_off6, w_alu_b;
    logic               w_legal, w_mem, w_two, w_first_we;
    logic [DATA_W-1:0]  w_first_addr;
    logic               w_timeout, w_br_taken, w_wr_en;
    logic [DATA_W-1:0]  w_wr_val;

    assign w_opc       = r_ir[15:12];
    assign w_dr        = r_ir[11:9];
    assign w_sr1       = r_ir[8:6];
    assign w_sr2       = r_ir[2:0];
    assign w_sext5     = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_sext6     = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_sext9     = {{(DATA_W-9){r_ir[8]}}, r_ir[8:0]};
    assign w_sext11    = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};
    assign w_pc_off9   = r_pc + w_sext9;
    assign w_pc_off11  = r_pc + w_sext11;
    assign w_base_off6 = r_rf[w_sr1] + w_sext6;
    assign w_alu_b     = r_ir[5] ? w_sext5 : r_rf[w_sr2];
    assign w_br_taken  = (r_ir[11] & r_n) | (r_ir[10] & r_z) | (r_ir[9] & r_p);
    assign w_timeout   = (MEM_TIMEOUT != 0) && (int'(r_cnt) == MEM_TIMEOUT - 1);

    assign o_cmd_ready     = (r_state == S_IDLE);
    assign o_done          = (r_state == S_EXEC);
    assign o_err           = o_done & r_err;
    assign o_ir            = r_ir;
    assign o_n             = r_n;
    assign o_z             = r_z;
    assign o_p             = r_p;
    assign o_mem_req       = (r_state == S_MEM1) || (r_state == S_MEM2);
    assign o_mem_we        = r_mem_we;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wdata     = r_mem_wdata;
    assign o_rf_debug_data = r_rf[i_rf_debug_addr];
    assign o_pc_debug_data = r_pc;

    // Decode of the offered command against the current IR: legality and first access.
    always_comb begin
        w_legal      = 1'b0;
        w_mem        = 1'b0;
        w_two        = 1'b0;
        w_first_we   = 1'b0;
        w_first_addr = r_pc;
        case (i_cmd_op)
            OP_FETCH: begin
                w_legal = 1'b1;
                w_mem   = 1'b1;
            end
            OP_ALU: w_legal = (w_opc == 4'b0001) || (w_opc == 4'b0101) || (w_opc == 4'b1001);
            OP_LOAD: begin
                case (w_opc)
                    4'b0010: begin w_legal = 1'b1; w_mem = 1'b1; w_first_addr = w_pc_off9; end
                    4'b0110: begin w_legal = 1'b1; w_mem = 1'b1; w_first_addr = w_base_off6; end
                    4'b1010: begin w_legal = 1'b1; w_mem = 1'b1; w_two = 1'b1; w_first_addr = w_pc_off9; end
                    4'b1110: w_legal = 1'b1;
                    default: ;
                endcase
            end
            OP_STORE: begin
                case (w_opc)
                    4'b0011: begin w_legal = 1'b1; w_mem = 1'b1; w_first_we = 1'b1; w_first_addr = w_pc_off9; end
                    4'b0111: begin w_legal = 1'b1; w_mem = 1'b1; w_first_we = 1'b1; w_first_addr = w_base_off6; end
                    4'b1011: begin w_legal = 1'b1; w_mem = 1'b1; w_two = 1'b1; w_first_addr = w_pc_off9; end
                    default: ;
                endcase
            end
            OP_BRANCH: w_legal = (w_opc == 4'b0000);
            OP_JUMP:   w_legal = (w_opc == 4'b1100) || (w_opc == 4'b0100);
            default: ;
        endcase
    end

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_val = '0;
        case (r_op)
            OP_ALU: begin
                w_wr_en = 1'b1;
                case (w_opc)
                    4'b0001: w_wr_val = r_rf[w_sr1] + w_alu_b;
                    4'b0101: w_wr_val = r_rf[w_sr1] & w_alu_b;
                    default: w_wr_val = ~r_rf[w_sr1];
                endcase
            end
            OP_LOAD: begin
                w_wr_en  = 1'b1;
                w_wr_val = (w_opc == 4'b1110) ? w_pc_off9 : r_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_cmd_valid) w_state_nxt = (w_legal && w_mem) ? S_MEM1 : S_EXEC;
            S_MEM1: begin
                if (i_mem_ack)      w_state_nxt = r_two ? S_GAP : S_POST;
                else if (w_timeout) w_state_nxt = S_EXEC;
            end
            S_GAP:  w_state_nxt = S_MEM2;
            S_MEM2: begin
                if (i_mem_ack)      w_state_nxt = S_POST;
                else if (w_timeout) w_state_nxt = S_EXEC;
            end
            S_POST: w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= o_mem_req ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Architectural state changes only in EXEC, so a timed-out command leaves no trace.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc        <= PC_RESET;
            r_ir        <= '0;
            for (int i = 0; i < 8; i++) r_rf[i] <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_p         <= 1'b0;
            r_op        <= OP_FETCH;
            r_err       <= 1'b0;
            r_two       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_data      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_op        <= i_cmd_op;
                        r_err       <= !w_legal;
                        r_two       <= w_two;
                        r_mem_addr  <= w_first_addr;
                        r_mem_we    <= w_first_we;
                        r_mem_wdata <= r_rf[w_dr];
                    end
                end
                S_MEM1: begin
                    if (i_mem_ack) begin
                        r_data <= i_mem_rdata;
                        if (r_two) begin
                            r_mem_addr <= i_mem_rdata;
                            r_mem_we   <= (r_op == OP_STORE);
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_MEM2: begin
                    if (i_mem_ack)      r_data <= i_mem_rdata;
                    else if (w_timeout) r_err  <= 1'b1;
                end
                S_EXEC: begin
                    if (!r_err) begin
                        if (w_wr_en) begin
                            r_rf[w_dr] <= w_wr_val;
                            r_n        <= w_wr_val[DATA_W-1];
                            r_z        <= (w_wr_val == '0);
                            r_p        <= !w_wr_val[DATA_W-1] && (w_wr_val != '0);
                        end
                        case (r_op)
                            OP_FETCH: begin
                                r_ir <= r_data[15:0];
                                r_pc <= r_pc + DATA_W'(1);
                            end
                            OP_BRANCH: if (w_br_taken) r_pc <= w_pc_off9;
                            OP_JUMP: begin
                                if (w_opc == 4'b1100) begin
                                    r_pc <= r_rf[w_sr1];
                                end else begin
                                    r_rf[7] <= r_pc;
                                    r_pc    <= r_ir[11] ? w_pc_off11 : r_rf[w_sr1];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
